// File: rtl/eth_pkg.sv
// Shared types and widths for the Ethernet transmit arbiter.
package eth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        GAP
    } eth_tx_arb_state_t;

    // Index width is sized for the largest supported source count (8),
    // so one width serves every legal N_SRC.
    localparam int N_SRC_MAX = 8;
    localparam int SRC_IDX_W = $clog2(N_SRC_MAX);
    localparam int IFG_CNT_W = 8;

endpackage

// File: rtl/eth_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, cyclically.
module eth_rr_pick
    import eth_pkg::*;
#(
    parameter int N_SRC = 3
) (
    input  logic [N_SRC-1:0]     req,
    input  logic [SRC_IDX_W-1:0] ptr,
    output logic [N_SRC-1:0]     pick,
    output logic                 any
);

    // Scan offsets 0..N_SRC-1 from ptr; the first live request wins.
    always_comb begin
        pick = '0;
        any  = 1'b0;
        for (int k = 0; k < N_SRC; k++) begin
            for (int j = 0; j < N_SRC; j++) begin
                if (!any && req[j] && (j == ((int'(ptr) + k) % N_SRC))) begin
                    pick[j] = 1'b1;
                    any     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/eth_tx_arb.sv
// Frame-granular round-robin arbiter in front of the MAC transmit stream.
// A grant is held from the first beat to the tlast handshake, then an
// inter-frame gap of IFG_CYCLES idle cycles precedes the next arbitration.
module eth_tx_arb
    import eth_pkg::*;
#(
    parameter int N_SRC      = 3,
    parameter int DATA_W     = 8,
    parameter int IFG_CYCLES = 12
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [N_SRC*DATA_W-1:0] s_tdata,
    input  logic [N_SRC-1:0]        s_tvalid,
    input  logic [N_SRC-1:0]        s_tlast,
    output logic [N_SRC-1:0]        s_tready,
    output logic [DATA_W-1:0]       m_tdata,
    output logic                    m_tvalid,
    output logic                    m_tlast,
    input  logic                    m_tready,
    output logic [N_SRC-1:0]        grant,
    output logic                    busy
);

    localparam logic [SRC_IDX_W-1:0] LAST_IDX = SRC_IDX_W'(N_SRC - 1);
    // With no gap the counter is never used; keep it at zero.
    localparam logic [IFG_CNT_W-1:0] GAP_LOAD =
        (IFG_CYCLES == 0) ? '0 : IFG_CNT_W'(IFG_CYCLES - 1);

    eth_tx_arb_state_t     r_state, w_state_nxt;
    logic [SRC_IDX_W-1:0]  r_ptr;
    logic [IFG_CNT_W-1:0]  r_gap_cnt;
    logic [N_SRC-1:0]      r_grant;
    logic [N_SRC-1:0]      w_pick;
    logic                  w_any;
    logic [SRC_IDX_W-1:0]  w_gidx;
    logic                  w_hs_last;

    eth_rr_pick #(.N_SRC(N_SRC)) u_pick (
        .req  (s_tvalid),
        .ptr  (r_ptr),
        .pick (w_pick),
        .any  (w_any)
    );

    assign grant     = r_grant;
    assign w_hs_last = m_tvalid & m_tready & m_tlast;

    // Encode the one-hot grant into the owner index for the pointer update.
    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (r_grant[i]) w_gidx = SRC_IDX_W'(i);
        end
    end

    // Output mux driven by the grant register; zero grant yields all-zero outputs.
    always_comb begin
        m_tdata  = '0;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        s_tready = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (r_grant[i]) begin
                m_tdata     = s_tdata[i*DATA_W +: DATA_W];
                m_tvalid    = s_tvalid[i];
                m_tlast     = s_tlast[i];
                s_tready[i] = m_tready;
            end
        end
    end

    // State register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic and busy flag.
    always_comb begin
        w_state_nxt = r_state;
        busy        = (r_state != IDLE);
        case (r_state)
            IDLE: if (w_any) w_state_nxt = XFER;
            XFER: if (w_hs_last) w_state_nxt = (IFG_CYCLES == 0) ? IDLE : GAP;
            GAP:  if (r_gap_cnt == '0) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Grant, round-robin pointer and gap counter.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_grant   <= '0;
            r_ptr     <= '0;
            r_gap_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_any) r_grant <= w_pick;
                XFER: if (w_hs_last) begin
                    r_grant   <= '0;
                    r_ptr     <= (w_gidx == LAST_IDX) ? '0 : w_gidx + SRC_IDX_W'(1);
                    r_gap_cnt <= GAP_LOAD;
                end
                GAP: if (r_gap_cnt != '0) r_gap_cnt <= r_gap_cnt - IFG_CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_arb.sv
// Bench for eth_tx_arb: behavioural owner/holdoff model checked every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_eth_tx_arb;

    localparam int N   = 3;
    localparam int DW  = 8;
    localparam int IFG = 12;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*DW-1:0] s_tdata;
    logic [N-1:0]    s_tvalid, s_tlast, s_tready, grant;
    logic [DW-1:0]   m_tdata;
    logic            m_tvalid, m_tlast, m_tready, busy;

    // Second instance with no inter-frame gap.
    logic [N*DW-1:0] z_tdata;
    logic [N-1:0]    z_tvalid, z_tlast, z_sready, z_grant;
    logic [DW-1:0]   z_mdata;
    logic            z_mvalid, z_mlast, z_mready, z_busy;

    always #5 clk = ~clk;

    eth_tx_arb #(.N_SRC(N), .DATA_W(DW), .IFG_CYCLES(IFG)) dut (
        .aclk(clk), .areset(rst),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .grant(grant), .busy(busy)
    );

    eth_tx_arb #(.N_SRC(N), .DATA_W(DW), .IFG_CYCLES(0)) dut_z (
        .aclk(clk), .areset(rst),
        .s_tdata(z_tdata), .s_tvalid(z_tvalid), .s_tlast(z_tlast), .s_tready(z_sready),
        .m_tdata(z_mdata), .m_tvalid(z_mvalid), .m_tlast(z_mlast), .m_tready(z_mready),
        .grant(z_grant), .busy(z_busy)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model: who owns the stream, where the next search starts, and how many
    // cycles remain before a new arbitration is allowed.
    int owner, mptr, hold;

    // Source generators.
    int rem[N], seq[N], stall[N], stall_at[N], vp[N];
    int newp, rp, lmin, lmax;
    bit toggle_rdy, rdy_ph;

    typedef struct {
        logic [N-1:0]  g;
        logic [N-1:0]  str;
        logic          mv, ml, bsy, rdy;
        logic [DW-1:0] d;
    } rec_t;
    rec_t lg[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] beat_data(input int i, input int s);
        return DW'(i * 64 + (s % 64));
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            s_tvalid[i] = (rem[i] > 0) && (stall[i] == 0) && (int'($urandom_range(99)) < vp[i]);
            s_tlast[i]  = (rem[i] == 1);
            s_tdata[i*DW +: DW] = beat_data(i, seq[i]);
        end
        m_tready = toggle_rdy ? rdy_ph : (int'($urandom_range(99)) < rp);
    endtask

    task automatic model_reset();
        owner = -1; mptr = 0; hold = 0;
        for (int i = 0; i < N; i++) begin
            rem[i] = 0; seq[i] = 0; stall[i] = 0; stall_at[i] = -1; vp[i] = 100;
        end
        newp = 0; rp = 100; lmin = 1; lmax = 1; toggle_rdy = 1'b0; rdy_ph = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        drive();
        z_tvalid = '0; z_tlast = '0; z_tdata = '0; z_mready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One cycle: compare at the falling edge, advance model and sources at the
    // rising edge, then drive the next inputs.
    task automatic step();
        logic [N-1:0]  eg, er;
        logic          emv, eml, eb;
        logic [DW-1:0] ed;
        bit            hs[N];
        bit            found;
        int            j;
        @(negedge clk);
        eg = '0; er = '0; emv = 1'b0; eml = 1'b0; ed = '0;
        if (owner >= 0) begin
            eg[owner] = 1'b1;
            er[owner] = m_tready;
            emv = s_tvalid[owner];
            eml = s_tlast[owner];
            ed  = s_tdata[owner*DW +: DW];
        end
        eb = (owner >= 0) || (hold > 0);
        vectors++;
        if (grant !== eg || s_tready !== er || m_tvalid !== emv || m_tlast !== eml ||
            m_tdata !== ed || busy !== eb) begin
            miscompares++;
            $display("FAIL cycle@%0t got g=%b r=%b v=%b l=%b d=%h b=%b want g=%b r=%b v=%b l=%b d=%h b=%b",
                     $time, grant, s_tready, m_tvalid, m_tlast, m_tdata, busy,
                     eg, er, emv, eml, ed, eb);
        end
        lg.push_back('{g:grant, str:s_tready, mv:m_tvalid, ml:m_tlast, bsy:busy, rdy:m_tready, d:m_tdata});
        for (int i = 0; i < N; i++) hs[i] = s_tvalid[i] && er[i];
        @(posedge clk);
        if (owner >= 0) begin
            if (hs[owner] && s_tlast[owner]) begin
                mptr  = (owner + 1) % N;
                owner = -1;
                hold  = IFG;
            end
        end else if (hold > 0) begin
            hold--;
        end else if (s_tvalid != '0) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                j = (mptr + k) % N;
                if (!found && s_tvalid[j]) begin
                    owner = j;
                    found = 1'b1;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (stall[i] > 0) stall[i]--;
            if (hs[i]) begin
                seq[i]++;
                rem[i]--;
                if (seq[i] == stall_at[i]) stall[i] = 3;
            end
            if (rem[i] == 0 && int'($urandom_range(99)) < newp)
                rem[i] = lmin + int'($urandom_range(lmax - lmin));
        end
        if (toggle_rdy) rdy_ph = !rdy_ph;
        #1 drive();
    endtask

    initial begin
        int nb, q, f0, l0, f2, bad, hsn, nst, cnt, prev, runlen;
        int starts[$];
        int runs[$];
        logic [DW-1:0] caps[$];
        logic [7:0] bits;
        logic [N-1:0] zg1;

        rst = 1'b0;
        model_reset();
        drive();
        z_tvalid = '0; z_tlast = '0; z_tdata = '0; z_mready = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst grant", grant, 0);
        check("rst busy", busy, 0);
        check("rst m_tvalid", m_tvalid, 0);
        check("rst m_tlast", m_tlast, 0);
        check("rst s_tready", s_tready, 0);
        check("rst m_tdata", m_tdata, 0);

        // Single source, 5-beat frame, always ready.
        do_reset(); lg.delete();
        rem[0] = 5; drive();
        repeat (20) step();
        check("t1 grant@0", lg[0].g, 0);
        check("t1 grant@1", lg[1].g, 3'b001);
        nb = 0; q = 0;
        for (int c = 1; c <= 5; c++) nb += int'(lg[c].mv);
        for (int c = 1; c <= 4; c++) q += int'(lg[c].ml);
        check("t1 beats", nb, 5);
        check("t1 early tlast", q, 0);
        check("t1 tlast@5", lg[5].ml, 1);
        q = 0;
        for (int c = 6; c <= 17; c++) q += int'(lg[c].mv == 1'b0 && lg[c].bsy == 1'b1 && lg[c].g == '0);
        check("t1 gap cycles", q, 12);
        check("t1 idle busy", lg[18].bsy, 0);

        // Contention: all three sources stream 2-beat frames continuously.
        do_reset(); lg.delete();
        lmin = 2; lmax = 2; newp = 100;
        for (int i = 0; i < N; i++) rem[i] = 2;
        drive();
        repeat (60) step();
        prev = 0; runlen = 0;
        for (int c = 0; c < lg.size(); c++) begin
            if (lg[c].g != '0) begin
                if (prev == 0) starts.push_back(int'(lg[c].g));
                runlen++;
            end else if (prev != 0) begin
                runs.push_back(runlen);
                runlen = 0;
            end
            prev = int'(lg[c].g);
        end
        check("t2 grant count", (starts.size() >= 4) ? 1 : 0, 1);
        if (starts.size() >= 4) begin
            check("t2 grant#0", starts[0], 3'b001);
            check("t2 grant#1", starts[1], 3'b010);
            check("t2 grant#2", starts[2], 3'b100);
            check("t2 grant#3", starts[3], 3'b001);
        end
        bad = 0;
        foreach (runs[k]) if (runs[k] != 2) bad++;
        check("t2 frame lengths", bad, 0);

        // Backpressure: ready toggles each cycle during a 4-beat frame.
        do_reset(); lg.delete();
        toggle_rdy = 1'b1; rdy_ph = 1'b1; rem[1] = 4; drive();
        repeat (16) step();
        hsn = 0; bad = 0; cnt = 0;
        for (int c = 0; c < lg.size(); c++) begin
            if (lg[c].mv && lg[c].rdy) begin
                hsn++;
                caps.push_back(lg[c].d);
            end
            if (lg[c].g == 3'b010) begin
                cnt++;
                if (lg[c].str != {1'b0, lg[c].rdy, 1'b0}) bad++;
            end
        end
        check("t3 handshakes", hsn, 4);
        check("t3 ready mirror", bad, 0);
        check("t3 xfer cycles", cnt, 8);
        if (caps.size() == 4)
            for (int k = 0; k < 4; k++) check("t3 data", caps[k], 64 + k);

        // Owner stall while source 2 keeps requesting.
        do_reset(); lg.delete();
        rem[0] = 6; stall_at[0] = 2; rem[2] = 2; drive();
        repeat (40) step();
        f0 = -1; l0 = -1; f2 = -1;
        for (int c = 0; c < lg.size(); c++) begin
            if (lg[c].g == 3'b001) begin
                if (f0 < 0) f0 = c;
                l0 = c;
            end
            if (lg[c].g == 3'b100 && f2 < 0) f2 = c;
        end
        check("t4 first grant", f0, 1);
        check("t4 hold span", l0 - f0 + 1, 9);
        bad = 0; nst = 0;
        if (f0 >= 0)
            for (int c = f0; c <= l0; c++) begin
                if (lg[c].g != 3'b001) bad++;
                if (!lg[c].mv) nst++;
            end
        check("t4 grant held", bad, 0);
        check("t4 stall cycles", nst, 3);
        check("t4 gap before src2", f2 - l0 - 1, 13);

        // Reset mid-frame: outputs drop at once, pointer returns to 0.
        do_reset(); lg.delete();
        rem[0] = 1; rem[1] = 6; drive();
        cnt = 0;
        for (int c = 0; c < 60 && cnt < 2; c++) begin
            step();
            if (lg[$].g == 3'b010 && lg[$].mv) cnt++;
        end
        check("t5 reached frame", cnt, 2);
        check("t5 pre-reset m_tvalid", m_tvalid, 1);
        rst = 1'b1;
        #1;
        check("t5 async grant", grant, 0);
        check("t5 async busy", busy, 0);
        check("t5 async m_tvalid", m_tvalid, 0);
        check("t5 async m_tlast", m_tlast, 0);
        check("t5 async s_tready", s_tready, 0);
        check("t5 async m_tdata", m_tdata, 0);
        model_reset(); drive();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        lg.delete();
        for (int i = 0; i < N; i++) rem[i] = 1;
        drive();
        repeat (3) step();
        check("t5 ptr after reset", lg[1].g, 3'b001);

        // Zero-gap instance: back-to-back one-beat frames.
        do_reset();
        z_tvalid = 3'b001; z_tlast = 3'b001; z_tdata = 24'h00005A; z_mready = 1'b1;
        bits = '0; zg1 = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            bits[c] = z_mvalid;
            if (c == 1) zg1 = z_grant;
            if (c == 2) check("t6 idle busy", z_busy, 0);
        end
        check("t6 valid pattern", bits, 8'hAA);
        check("t6 grant", zg1, 3'b001);
        z_tvalid = '0; z_tlast = '0;

        // Randomized soak against the model.
        do_reset();
        newp = 30; lmin = 1; lmax = 6; rp = 70;
        for (int i = 0; i < N; i++) vp[i] = 75;
        drive();
        repeat (3000) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
